regfile_wb_demux: RTL
=====================

Name: regfile_wb_demux

Overview:
- Destination side of the register-select path: takes the 5-bit destination register number and 32-bit write-back value chosen upstream, and decodes them into a one-hot write of a 32x32 register file.
- Provides two combinational read ports for the decode stage.
- Register 0 is hardwired to zero.
- Sits between the write-back select muxes and the ALU operand muxes in the MIPS datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  write request for this cycle.
- wr_addr  input  ADDR_W  destination register index (rd/rt after select).
- wr_data  input  DATA_W  write-back value.
- rd_addr1  input  ADDR_W  read port 1 index (rs).
- rd_data1  output  DATA_W  read port 1 value.
- rd_addr2  input  ADDR_W  read port 2 index (rt).
- rd_data2  output  DATA_W  read port 2 value.
- wr_onehot  output  2**ADDR_W  registered one-hot decode of the last accepted write; zero if none.
- wr_count  output  16  number of accepted writes since reset.

Behaviour:
- Reset: sampled on rising clk while rst_n=0.
  - Clears all registers to 0, wr_onehot to 0 and wr_count to 0.
  - A write presented in a reset cycle is dropped.
- Write:
  - On the rising edge with rst_n=1, wr_en=1 and wr_addr!=0, the register at wr_addr takes wr_data.
  - Latency is 1 cycle: the new value is visible on the read ports from the next cycle.
- wr_addr=0:
  - A write is accepted for handshake purposes but has no effect on storage, so register 0 always reads 0.
  - wr_onehot is set to 0; wr_count does not increment.
- Decode:
  - One clock after an accepted nonzero write, wr_onehot has exactly bit[wr_addr] set.
  - wr_onehot holds that value until the next edge, then returns to 0 if wr_en=0.
- wr_count:
  - Increments by 1 per accepted nonzero write.
  - Saturates at 16'hFFFF and does not wrap.
- Reads:
  - Combinational from rd_addr*.
  - Index 0 always returns 0.
  - Both ports may address the same register, and both return the same value.
- Simultaneous read and write to the same nonzero index: behaviour is set by WRITE_BYPASS_EN (see Optional Feature).
- Reset mid-operation: registers are cleared on that edge regardless of wr_en; reads in the following cycle return 0.
- No X propagation:
  - Reads of any index after reset are defined.
  - wr_addr/wr_data are ignored when wr_en=0.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When wr_en=1, rst_n=1 and rd_addrN==wr_addr!=0, rd_dataN returns wr_data combinationally in the same cycle (write-through).
  - This removes the WB-to-ID hazard.
- Undefined:
  - rd_dataN returns the stored (old) value during the write cycle.
  - The new value is visible the cycle after.
- wr_onehot and wr_count are identical in both builds.

Test Plan:
- Reset then read: rst_n=0 one cycle with wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF.
  - Response: rd_addr1=5 reads 0, wr_count=0, wr_onehot=0.
- Basic write: wr_en=1, wr_addr=7, wr_data=32'h12345678.
  - Response: next cycle rd_addr1=7 gives 32'h12345678 and wr_onehot=32'h00000080; wr_count=1 after that write.
- Zero register: write 32'hFFFFFFFF to addr 0.
  - Response: rd_addr1=0 and rd_addr2=0 give 0; wr_onehot=0; wr_count unchanged.
- Same-cycle read/write: reg 9 holds 32'h1; write 32'h2 to 9 while rd_addr2=9.
  - With bypass: rd_data2=32'h2 that cycle.
  - Without bypass: rd_data2=32'h1, then 32'h2 the next cycle.
- Full sweep: write i*32'h01010101 to addrs 1..31 in consecutive cycles, then read all 32 on both ports.
  - Response: every value matches, index 0 reads 0, wr_count=31.
- Mid-stream reset: after the sweep, rst_n=0 for one cycle.
  - Response: all reads return 0 and wr_count=0 in the next cycle.

Source files
------------

// File: rtl/regfile_wb_demux.sv
// regfile_wb_demux: write-back destination decode and 32x32 register file.
//
// Decodes the selected destination index into a one-hot write strobe for the
// register array. It also provides two combinational read ports for the decode
// stage. Register 0 is hardwired to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (clears array, wr_onehot, wr_count)
//   wr_en      write request this cycle
//   wr_addr    destination register index
//   wr_data    write-back value
//   rd_addr1   read port 1 index (rs)
//   rd_data1   read port 1 value (combinational)
//   rd_addr2   read port 2 index (rt)
//   rd_data2   read port 2 value (combinational)
//   wr_onehot  registered one-hot of the last accepted nonzero write, else 0
//   wr_count   saturating count of accepted nonzero writes since reset
//
// Build option:
//   REGFILE_WRITE_BYPASS_EN - when defined, a read that hits the index being
//   written in the same cycle returns wr_data (write-through). When undefined,
//   the read returns the stored value and the new value appears a cycle later.

module regfile_wb_demux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [ADDR_W-1:0]      rd_addr1,
    output logic [DATA_W-1:0]      rd_data1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic [DATA_W-1:0]      rd_data2,
    output logic [(2**ADDR_W)-1:0] wr_onehot,
    output logic [15:0]            wr_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  wr_onehot_q;
    logic [DEPTH-1:0]  wr_onehot_d;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;

    logic              wr_accept_c;
    logic [DEPTH-1:0]  wr_sel_c;

    // A write only touches storage when it targets a nonzero index outside reset.
    assign wr_accept_c = rst_n && wr_en && (wr_addr != '0);

    // One-hot demux of the destination index.
    always_comb begin
        wr_sel_c = '0;
        if (wr_accept_c) begin
            wr_sel_c = DEPTH'(1) << wr_addr;
        end
    end

    // Next-state for the register array: each row takes wr_data on its strobe.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_sel_c[i]) begin
                mem_d[i] = wr_data;
            end
        end
        // Row 0 never holds anything but zero.
        mem_d[0] = '0;
    end

    // Decode and counter next-state; counter saturates instead of wrapping.
    always_comb begin
        wr_onehot_d = wr_sel_c;
        wr_count_d  = wr_count_q;
        if (wr_accept_c && (wr_count_q != CNT_MAX)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_onehot_q <= '0;
            wr_count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_onehot_q <= wr_onehot_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Read port 1.
    always_comb begin
        rd_data1 = '0;
        if (rd_addr1 != '0) begin
            rd_data1 = mem_q[rd_addr1];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wr_accept_c && (rd_addr1 == wr_addr)) begin
                rd_data1 = wr_data;
            end
`endif
        end
    end

    // Read port 2.
    always_comb begin
        rd_data2 = '0;
        if (rd_addr2 != '0) begin
            rd_data2 = mem_q[rd_addr2];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wr_accept_c && (rd_addr2 == wr_addr)) begin
                rd_data2 = wr_data;
            end
`endif
        end
    end

    assign wr_onehot = wr_onehot_q;
    assign wr_count  = wr_count_q;

endmodule
